nibble_serial_tx: RTL and testbench
===================================

// Module: nibble_serial_tx
// PURPOSE
//  Parallel-to-serial transmitter: takes a DATA_W-bit word from a holding register over a
//  load/ready handshake and shifts it out on a single line as a framed serial stream:
//  start bit, data LSB-first, optional even-parity bit, stop bit.
//  It is the sending end of the lab serial link. It drains the 4-bit register bank onto one wire.
// PARAMETERS
//  DATA_W        4  data bits per frame (1..8)
//  CLKS_PER_BIT  4  clk cycles each serial bit is held (>=1)
//  PARITY_EN     0  1 = insert even-parity bit after data; 0 = no parity bit
// PORTS
//  clk    in   1       sole clock, rising edge
//  rst    in   1       synchronous, active-low reset (sampled on clk rising edge only)
//  load   in   1       request to send din; accepted only when ready=1
//  din    in   DATA_W  word to send, captured on the accepting edge
//  ready  out  1       1 = idle, can accept load
//  tx     out  1       serial line, idle-high, registered
//  busy   out  1       1 = frame in progress (START..STOP)
//  done   out  1       one-cycle pulse on the cycle the STOP bit completes
// BEHAVIOUR
//  - Reset (rst=0 at an edge): state=IDLE, tx=1, ready=1, busy=0, done=0, shift reg=0,
//    bit timer=0, bit index=0. Reset wins over everything, including mid-frame: the line
//    returns high on the next edge and the partial frame is abandoned, with no done pulse.
//  - FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//  - IDLE: tx=1, ready=1. An edge with load=1 captures din into the shift register.
//    It also latches parity = ^din and enters START. tx=0 is visible from the next cycle.
//  - Each bit state holds tx for exactly CLKS_PER_BIT cycles. The bit timer counts
//    0..CLKS_PER_BIT-1 and the state advances when the timer hits CLKS_PER_BIT-1.
//  - DATA: tx = shift[0], LSB first. The register shifts right at each bit boundary.
//    The bit index runs 0..DATA_W-1, and the FSM leaves DATA after bit DATA_W-1.
//  - PARITY: tx = XOR of the captured data bits (even parity).
//  - STOP: tx=1. On its last timer cycle done=1 for exactly one cycle, and the next state is IDLE.
//  - Frame length from the accepting edge to the return to IDLE is
//    (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles. Because IDLE lasts at least 1 cycle,
//    back-to-back frames have a stop level of CLKS_PER_BIT+1 cycles.
//  - load while ready=0 is ignored and not queued. din changes after capture have no effect.
//  - busy = ~ready at all times. ready is 0 from the cycle after acceptance until IDLE is re-entered.
//  - All outputs come from registers or pure state decode. There is no combinational path from
//    load/din to tx.
// STRUCTURE
//  - Shared package nibble_serial_pkg: state encoding constants
//    (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, 3-bit), TX_IDLE_LEVEL=1'b1,
//    and a function computing timer width from CLKS_PER_BIT.
//  - One sub-module: bit_period_timer (clk, rst, clear, tick). It is a modulo-CLKS_PER_BIT counter
//    with a terminal-count pulse, cleared on frame start. The FSM, shift register and parity stay
//    in the top module.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with load=1 -> tx=1, ready=1, busy=0, done=0 throughout.
//  2. DATA_W=4, CLKS_PER_BIT=4, PARITY_EN=0, send din=4'b1010 -> tx holds 0,0,1,0,1,1 for
//     4 cycles each. done pulses at cycle 24 after acceptance, then ready=1.
//  3. PARITY_EN=1, din=4'b0111 -> parity bit = 1 and the frame is 28 cycles.
//     With din=4'b0011, parity bit = 0.
//  4. Pulse load=1 with din=4'hF during the DATA state -> ignored. The frame in flight
//     is unchanged and no second frame is sent.
//  5. Drop rst to 0 during bit 2 of DATA -> next edge tx=1, ready=1, no done pulse.
//     A new load is accepted after release.
//  6. Hold load=1 continuously with din=4'h5 then 4'hA -> two frames separated by exactly one
//     IDLE cycle. Each decodes correctly, and done pulses once per frame.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble serial transmitter: FSM state encoding, line idle level,
// and the bit-period timer width helper.
package nibble_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // At least one bit so CLKS_PER_BIT=1 still yields a legal counter.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Modulo-CLKS_PER_BIT counter; tick marks the last cycle of each serial bit period.
module bit_period_timer
  import nibble_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = timer_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (clear) cnt_d = '0;
  end

  // NOTE: reset is synchronous (sampled only at the clock edge) and state uses <= so every
  // flop updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
module nibble_serial_tx
  import nibble_serial_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              tick;

  // Timer is held at zero while idle so the start bit always gets a full period.
  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          shift_d = din;
          par_d   = ^din;
          idx_d   = '0;
        end
      end
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so the tx flop lines up with the state flop.
    tx_d = TX_IDLE_LEVEL;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= TX_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx    = tx_q;
  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign done  = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench: two transmitters (without and with parity) share one randomized stimulus.
module tb_nibble_serial_tx;

  localparam int W   = 4;
  localparam int CPB = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din  = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  acc;
  } exp_t;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int FRAME = (2 + W + g) * CPB;

    logic        ready, tx, busy, done;
    exp_t        sb[$];
    bit          m_active = 1'b0;
    int unsigned m_a = 0;
    int unsigned cyc = 0;
    logic        tx_hist [0:1023];

    nibble_serial_tx #(
      .DATA_W      (W),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (g)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .din  (din),
      .ready(ready),
      .tx   (tx),
      .busy (busy),
      .done (done)
    );

    // Line level expected in cycle j of a frame carrying d.
    function automatic logic exp_bit(input logic [W-1:0] d, input int j);
      int b;
      b = j / CPB;
      if (b == 0) return 1'b0;
      if (b <= W) return d[b-1];
      if (g != 0 && b == W + 1) return ^d;
      return 1'b1;
    endfunction

    // Reference model: an accepted frame occupies FRAME cycles, loads while busy are dropped.
    always @(posedge clk) begin
      cyc++;
      if (!rst) begin
        m_active = 1'b0;
        sb.delete();
      end else if (!m_active) begin
        if (load) begin
          m_active = 1'b1;
          m_a      = cyc;
          sb.push_back('{data: din, acc: cyc});
        end
      end else if (cyc == m_a + FRAME) begin
        m_active = 1'b0;
      end
    end

    always @(negedge clk) begin
      bit          m_done;
      exp_t        e;
      logic [63:0] obs, expv;
      m_done = m_active && (cyc == m_a + FRAME - 1);
      tx_hist[cyc % 1024] = tx;
      check($sformatf("ready%0d", g), 64'(ready), 64'(!m_active));
      check($sformatf("busy%0d", g), 64'(busy), 64'(m_active));
      check($sformatf("done%0d", g), 64'(done), 64'(m_done));
      if (!m_active) check($sformatf("tx_idle%0d", g), 64'(tx), 64'(1'b1));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("done_unexpected%0d", g), 64'(1), 64'(0));
        end else begin
          e    = sb.pop_front();
          obs  = '0;
          expv = '0;
          for (int j = 0; j < FRAME; j++) begin
            obs[j]  = tx_hist[(e.acc + j) % 1024];
            expv[j] = exp_bit(e.data, j);
          end
          check($sformatf("done_time%0d", g), 64'(cyc), 64'(e.acc + FRAME - 1));
          check($sformatf("frame%0d_din%0h", g, e.data), obs, expv);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    load = 1'b1;
    din  = d;
    @(negedge clk);
    load = 1'b0;
    din  = W'($urandom);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    // Reset held with load asserted: nothing may start.
    rst  = 1'b0;
    load = 1'b1;
    din  = 4'hC;
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    repeat (2) @(negedge clk);

    send(4'b1010);
    send(4'b0111);
    send(4'b0011);

    // Load attempt in the middle of the data bits must be ignored.
    load = 1'b1;
    din  = 4'b1010;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    load = 1'b1;
    din  = 4'hF;
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    // Reset during data bit 2 abandons the frame.
    load = 1'b1;
    din  = 4'b0110;
    @(negedge clk);
    load = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(4'b1001);

    // Continuous load: back-to-back frames with one idle cycle between them.
    load = 1'b1;
    din  = 4'h5;
    @(negedge clk);
    din  = 4'hA;
    repeat (70) @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 3) == 0);
      din  = W'($urandom);
      rst  = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst  = 1'b1;
    load = 1'b0;
    repeat (40) @(negedge clk);

    check("sb_empty0", 64'(g_chk[0].sb.size()), 64'(0));
    check("sb_empty1", 64'(g_chk[1].sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
